// File: rtl/dfe_apb_pkg.sv
// Shared constants for the DFE APB host master: bus widths, register address map,
// component-select encodings, FSM state type and the address decode function.
package dfe_apb_pkg;

    localparam int PDATA_WIDTH = 32;
    localparam int ADDR_WIDTH  = 7;
    localparam int COEFF_WIDTH = 20;
    localparam int N_TAP       = 72;
    localparam int NUM_DENUM   = 5;
    localparam int COMP        = 5;

    // Address map, relative to the first register after the coefficient banks
    localparam int ADDR_BASE   = N_TAP + NUM_DENUM;
    localparam int CIC_R_ADDR  = ADDR_BASE;
    localparam int CTRL_HI     = ADDR_BASE + 6;
    localparam int FD_STAT_HI  = ADDR_BASE + 8;
    localparam int IIR_STAT_HI = ADDR_BASE + 14;
    localparam int CIC_STAT_HI = ADDR_BASE + 16;
    localparam int FIR_STAT_HI = ADDR_BASE + 18;
    localparam int ADDR_LIMIT  = ADDR_BASE + 19;

    localparam logic [COMP-1:0] SEL_NONE = 5'b00000;
    localparam logic [COMP-1:0] SEL_FD   = 5'b00001;
    localparam logic [COMP-1:0] SEL_IIR  = 5'b00010;
    localparam logic [COMP-1:0] SEL_CIC  = 5'b00100;
    localparam logic [COMP-1:0] SEL_CTRL = 5'b01000;
    localparam logic [COMP-1:0] SEL_FIR  = 5'b10000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // SEL_NONE marks an address with no backing register
    function automatic logic [COMP-1:0] addr_to_sel(input logic [ADDR_WIDTH-1:0] addr);
        logic [31:0]     a;
        logic [COMP-1:0] sel;
        a = 32'(addr);
        if (a < 32'(N_TAP)) begin
            sel = SEL_FD;
        end else if (a < 32'(ADDR_BASE)) begin
            sel = SEL_IIR;
        end else if (a == 32'(CIC_R_ADDR)) begin
            sel = SEL_CIC;
        end else if (a <= 32'(CTRL_HI)) begin
            sel = SEL_CTRL;
        end else if (a <= 32'(FD_STAT_HI)) begin
            sel = SEL_FD;
        end else if (a <= 32'(IIR_STAT_HI)) begin
            sel = SEL_IIR;
        end else if (a <= 32'(CIC_STAT_HI)) begin
            sel = SEL_CIC;
        end else if (a <= 32'(FIR_STAT_HI)) begin
            sel = SEL_FIR;
        end else begin
            sel = SEL_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/apb_host_master_if.sv
// Host command / response and master bus signals of the DFE APB host master.
interface apb_host_master_if;
    import dfe_apb_pkg::*;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_write;
    logic [ADDR_WIDTH-1:0]  cmd_addr;
    logic [PDATA_WIDTH-1:0] cmd_wdata;
    logic                   MTRANS;
    logic                   MWRITE;
    logic [COMP-1:0]        MSELx;
    logic [ADDR_WIDTH-1:0]  MADDR;
    logic [COEFF_WIDTH-1:0] MWDATA;
    logic [PDATA_WIDTH-1:0] MRDATA;
    logic                   rsp_valid;
    logic                   rsp_err;
    logic [PDATA_WIDTH-1:0] rsp_rdata;
    logic                   busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, MRDATA,
        output cmd_ready, MTRANS, MWRITE, MSELx, MADDR, MWDATA,
               rsp_valid, rsp_err, rsp_rdata, busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, MRDATA,
        input  cmd_ready, MTRANS, MWRITE, MSELx, MADDR, MWDATA,
               rsp_valid, rsp_err, rsp_rdata, busy
    );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full and empty
// are distinguished without a separate counter.
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer advance; reset flushes the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage write; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/apb_host_master.sv
// Host-side master for the DFE APB register block: queues host commands, decodes the
// component select and runs one SETUP/ACCESS transfer per command with a one-cycle response.
module apb_host_master
    import dfe_apb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    apb_host_master_if.master  bus
);

    localparam int FIFO_W = 1 + ADDR_WIDTH + PDATA_WIDTH;

    logic                   push_s;
    logic                   pop_s;
    logic                   empty_s;
    logic                   full_s;
    logic [FIFO_W-1:0]      push_data_s;
    logic [FIFO_W-1:0]      head_s;
    logic                   head_write_s;
    logic [ADDR_WIDTH-1:0]  head_addr_s;
    logic [PDATA_WIDTH-1:0] head_wdata_s;
    logic [COMP-1:0]        head_sel_s;
    logic                   unused_wdata_s;

    state_e                 state_r,     state_s;
    logic                   err_r,       err_s;
    logic                   mtrans_r,    mtrans_s;
    logic                   mwrite_r,    mwrite_s;
    logic [COMP-1:0]        msel_r,      msel_s;
    logic [ADDR_WIDTH-1:0]  maddr_r,     maddr_s;
    logic [COEFF_WIDTH-1:0] mwdata_r,    mwdata_s;
    logic                   rsp_valid_r, rsp_valid_s;
    logic                   rsp_err_r,   rsp_err_s;
    logic [PDATA_WIDTH-1:0] rsp_rdata_r, rsp_rdata_s;

    assign push_s      = bus.cmd_valid && !full_s;
    assign push_data_s = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    assign {head_write_s, head_addr_s, head_wdata_s} = head_s;
    assign head_sel_s  = addr_to_sel(head_addr_s);
    // Coefficients are narrower than the host word; the upper bits are dropped
    assign unused_wdata_s = ^head_wdata_s[PDATA_WIDTH-1:COEFF_WIDTH];

    cmd_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .empty     (empty_s),
        .full      (full_s)
    );

    // Next state and next registered outputs; bus registers double as the holding registers
    always_comb begin
        state_s     = state_r;
        err_s       = err_r;
        mtrans_s    = mtrans_r;
        mwrite_s    = mwrite_r;
        msel_s      = msel_r;
        maddr_s     = maddr_r;
        mwdata_s    = mwdata_r;
        rsp_valid_s = 1'b0;
        rsp_err_s   = 1'b0;
        rsp_rdata_s = {PDATA_WIDTH{1'b0}};
        pop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    state_s = SETUP;
                    if (head_sel_s == SEL_NONE) begin
                        err_s = 1'b1;
                    end else begin
                        err_s    = 1'b0;
                        mtrans_s = 1'b1;
                        mwrite_s = head_write_s;
                        msel_s   = head_sel_s;
                        maddr_s  = head_addr_s;
                        mwdata_s = head_wdata_s[COEFF_WIDTH-1:0];
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                if (err_r) begin
                    state_s     = RESP;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b1;
                end else begin
                    state_s = ACCESS;
                end
            end
            ACCESS: begin
                state_s     = RESP;
                mtrans_s    = 1'b0;
                rsp_valid_s = 1'b1;
                if (mwrite_r) begin
                    rsp_rdata_s = {PDATA_WIDTH{1'b0}};
                end else begin
                    rsp_rdata_s = bus.MRDATA;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s  = IDLE;
                mtrans_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer without a response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            err_r       <= 1'b0;
            mtrans_r    <= 1'b0;
            mwrite_r    <= 1'b0;
            msel_r      <= {COMP{1'b0}};
            maddr_r     <= {ADDR_WIDTH{1'b0}};
            mwdata_r    <= {COEFF_WIDTH{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {PDATA_WIDTH{1'b0}};
        end else begin
            state_r     <= state_s;
            err_r       <= err_s;
            mtrans_r    <= mtrans_s;
            mwrite_r    <= mwrite_s;
            msel_r      <= msel_s;
            maddr_r     <= maddr_s;
            mwdata_r    <= mwdata_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_err_r   <= rsp_err_s;
            rsp_rdata_r <= rsp_rdata_s;
        end
    end

    assign bus.cmd_ready = !full_s;
    assign bus.busy      = !empty_s || (state_r != IDLE);
    assign bus.MTRANS    = mtrans_r;
    assign bus.MWRITE    = mwrite_r;
    assign bus.MSELx     = msel_r;
    assign bus.MADDR     = maddr_r;
    assign bus.MWDATA    = mwdata_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_rdata = rsp_rdata_r;

endmodule
